// File: rtl/frame_snapshot.sv
// Captures one decoded frame from the byte mux into a local snapshot and holds
// it stable for the microcontroller until rd_ack; later frames only flag overrun.
module frame_snapshot #(
    parameter logic [3:0] REQUIRE_MASK  = 4'hF,
    parameter bit         ABORT_ON_DROP = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mux_valid,
    input  logic [7:0] mux_data,
    output logic [3:0] mux_address,
    input  logic [3:0] rd_address,
    output logic [7:0] rd_data,
    input  logic       rd_ack,
    output logic       frame_ready,
    output logic       overrun,
    output logic [7:0] frame_count,
    output logic [7:0] reject_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, READY} state_e;

    localparam int  NUM_BYTES = 13;
    localparam logic [3:0] LAST_SLOT = 4'd12;

    state_e                        state_q, state_d;
    logic [3:0]                    slot_q, slot_d;
    logic [NUM_BYTES-1:0][7:0]     snap_q;
    logic                          wr_en;
    logic                          valid_prev_q;
    logic                          overrun_q, overrun_d;
    logic [7:0]                    fcnt_q, fcnt_d;
    logic [7:0]                    rcnt_q, rcnt_d;
    logic [7:0]                    rd_data_q, rd_data_d;
    logic                          rise;

    assign rise = mux_valid & ~valid_prev_q;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        wr_en     = 1'b0;
        fcnt_d    = fcnt_q;
        rcnt_d    = rcnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = CAPTURE;
                    slot_d  = 4'd0;
                end
            end
            CAPTURE: begin
                if (ABORT_ON_DROP && !mux_valid) begin
                    state_d = IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (slot_q == LAST_SLOT) begin
                        // Judge the validation byte as it arrives, not from the buffer.
                        if ((mux_data[3:0] & REQUIRE_MASK) == REQUIRE_MASK) begin
                            state_d = READY;
                            fcnt_d  = fcnt_q + 8'd1;
                        end else begin
                            state_d = IDLE;
                            rcnt_d  = rcnt_q + 8'd1;
                        end
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            READY: begin
                if (rd_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise while busy beats a simultaneous rd_ack clear.
    always_comb begin
        overrun_d = overrun_q;
        if (rise && state_q != IDLE)
            overrun_d = 1'b1;
        else if (rd_ack && state_q == READY)
            overrun_d = 1'b0;
    end

    always_comb begin
        rd_data_d = 8'h00;
        if (rd_address <= 4'd11)
            rd_data_d = snap_q[rd_address];
        else if (rd_address == 4'hF)
            rd_data_d = {4'b0000, snap_q[LAST_SLOT][3:0]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            slot_q       <= 4'd0;
            snap_q       <= '0;
            valid_prev_q <= 1'b0;
            overrun_q    <= 1'b0;
            fcnt_q       <= 8'd0;
            rcnt_q       <= 8'd0;
            rd_data_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            valid_prev_q <= mux_valid;
            overrun_q    <= overrun_d;
            fcnt_q       <= fcnt_d;
            rcnt_q       <= rcnt_d;
            rd_data_q    <= rd_data_d;
            if (wr_en) snap_q[slot_q] <= mux_data;
        end
    end

    assign mux_address  = (state_q == CAPTURE) ? ((slot_q == LAST_SLOT) ? 4'hF : slot_q) : 4'h0;
    assign frame_ready  = (state_q == READY);
    assign overrun      = overrun_q;
    assign frame_count  = fcnt_q;
    assign reject_count = rcnt_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_frame_snapshot.sv
// Scoreboard bench for frame_snapshot: mux model in memory, expectations queued
// at stimulus time and popped when the DUT output is sampled on the falling edge.
module tb_frame_snapshot;

    logic       clock = 1'b0;
    logic       reset;
    logic       mux_valid;
    logic [7:0] mux_data;
    logic [3:0] mux_address;
    logic [3:0] rd_address;
    logic [7:0] rd_data;
    logic       rd_ack;
    logic       frame_ready;
    logic       overrun;
    logic [7:0] frame_count;
    logic [7:0] reject_count;

    logic [7:0]  mem [16];
    logic [31:0] sb [$];
    logic [7:0]  exp_fc, exp_rc;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    always_comb mux_data = mem[mux_address];

    frame_snapshot dut (
        .clock        (clock),
        .reset        (reset),
        .mux_valid    (mux_valid),
        .mux_data     (mux_data),
        .mux_address  (mux_address),
        .rd_address   (rd_address),
        .rd_data      (rd_data),
        .rd_ack       (rd_ack),
        .frame_ready  (frame_ready),
        .overrun      (overrun),
        .frame_count  (frame_count),
        .reject_count (reject_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem(input logic [7:0] vbyte);
        for (int i = 0; i < 16; i++) mem[i] = (i < 12) ? 8'(8'h10 + i) : 8'h00;
        mem[15] = vbyte;
    endtask

    // Drop valid for a cycle, raise it, and follow the 13-slot address walk.
    task automatic capture();
        mux_valid = 1'b0;
        @(negedge clock);
        mux_valid = 1'b1;
        for (int i = 0; i < 12; i++) sb.push_back(32'(i));
        sb.push_back(32'hF);
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            chk("mux_addr", mux_address, sb.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        rd_address = a;
        sb.push_back(32'(exp));
        @(negedge clock);
        chk("rd_data", rd_data, sb.pop_front());
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mux_valid = 1'b0; rd_address = 4'd0; rd_ack = 1'b0;
        exp_fc = 8'd0; exp_rc = 8'd0;
        load_mem(8'h0F);
        repeat (2) @(negedge clock);
        chk("rst_addr", mux_address, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_ready", frame_ready, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_rc", reject_count, 0);
        reset = 1'b1;
        @(negedge clock);

        // nominal
        capture(); exp_fc++;
        chk("nom_ready", frame_ready, 1);
        chk("nom_fc", frame_count, exp_fc);
        rd(4'd5, 8'h15);
        rd(4'd15, 8'h0F);
        rd(4'd13, 8'h00);
        rd(4'd0, 8'h10);
        rd(4'd11, 8'h1B);
        ack();
        chk("nom_ack_ready", frame_ready, 0);

        // mask reject
        load_mem(8'h07);
        capture(); exp_rc++;
        chk("rej_ready", frame_ready, 0);
        chk("rej_rc", reject_count, exp_rc);
        chk("rej_fc", frame_count, exp_fc);
        chk("rej_addr", mux_address, 0);

        // overrun while ready
        load_mem(8'h0F);
        capture(); exp_fc++;
        chk("ovr_ready", frame_ready, 1);
        mem[5] = 8'hAA;
        mux_valid = 1'b0; @(negedge clock);
        mux_valid = 1'b1; @(negedge clock);
        chk("ovr_set", overrun, 1);
        chk("ovr_still_ready", frame_ready, 1);
        rd(4'd5, 8'h15);
        ack();
        chk("ovr_ack_ready", frame_ready, 0);
        chk("ovr_ack_clr", overrun, 0);
        capture(); exp_fc++;
        chk("ovr_next_fc", frame_count, exp_fc);
        rd(4'd5, 8'hAA);

        // rise coincident with rd_ack: ack clears, rise re-sets overrun
        mux_valid = 1'b0; @(negedge clock);
        mux_valid = 1'b1; rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        chk("race_ovr", overrun, 1);
        chk("race_ready", frame_ready, 0);
        @(negedge clock);
        chk("race_idle", mux_address, 0);

        // abort at slot 4
        mux_valid = 1'b0; @(negedge clock);
        mux_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb.push_back(32'(k));
            @(negedge clock);
            chk("abort_addr", mux_address, sb.pop_front());
        end
        mux_valid = 1'b0;
        @(negedge clock);
        chk("abort_idle", mux_address, 0);
        chk("abort_ready", frame_ready, 0);
        chk("abort_fc", frame_count, exp_fc);
        chk("abort_rc", reject_count, exp_rc);

        // commit until the frame counter wraps
        mem[5] = 8'h15;
        while (exp_fc != 8'd0) begin
            capture(); exp_fc++;
            ack();
        end
        chk("wrap_fc", frame_count, 0);
        chk("wrap_rc", reject_count, exp_rc);

        // build nonzero state, then reset asynchronously mid-capture
        capture(); exp_fc++;
        rd_address = 4'd5;
        mux_valid = 1'b0; @(negedge clock);
        mux_valid = 1'b1; rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        chk("pre_fc", frame_count, exp_fc);
        chk("pre_ovr", overrun, 1);
        chk("pre_rd", rd_data, 8'h15);
        mux_valid = 1'b0; @(negedge clock);
        mux_valid = 1'b1;
        repeat (4) @(negedge clock);
        chk("pre_addr", mux_address, 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_addr", mux_address, 0);
        chk("arst_rd", rd_data, 0);
        chk("arst_ready", frame_ready, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_fc", frame_count, 0);
        chk("arst_rc", reject_count, 0);
        @(negedge clock);
        reset = 1'b1;
        mux_valid = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
